// File: rtl/dir_mem_rr_sched.sv
// Round-robin arbiter sharing the single directory-memory port between NUM_REQ coherence FSMs.
// Optional forced release of a stalled grant is built when DIR_SCHED_TIMEOUT_EN is defined.
package param_pkg;
  localparam int DCACHE_TAG_WIDTH   = 20;
  localparam int DCACHE_INDEX_WIDTH = 6;
  localparam int CPU_ID_WIDTH       = 2;
  localparam int N_CPU              = 4;

  typedef enum logic [1:0] {
    READ_OP    = 2'd0,
    WRITE_OP   = 2'd1,
    UPGRADE_OP = 2'd2,
    EVICT_OP   = 2'd3
  } op_dir_t;
endpackage

module dir_mem_rr_sched
  import param_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                            clk,
  input  logic                                            resetn,
  input  logic [NUM_REQ-1:0]                              valid_f2d_i,
  input  op_dir_t [NUM_REQ-1:0]                           op_f2d_i,
  input  logic [NUM_REQ-1:0][DCACHE_TAG_WIDTH-1:0]        tag_f2d_i,
  input  logic [NUM_REQ-1:0][DCACHE_INDEX_WIDTH-1:0]      index_f2d_i,
  input  logic [NUM_REQ-1:0][CPU_ID_WIDTH-1:0]            cpu_id_f2d_i,
  input  logic                                            ack_d2f_i,
  input  logic [N_CPU-1:0]                                sharers_d2f_i,
  output logic                                            valid_f2d_o,
  output op_dir_t                                         op_f2d_o,
  output logic [DCACHE_TAG_WIDTH-1:0]                     tag_f2d_o,
  output logic [DCACHE_INDEX_WIDTH-1:0]                   index_f2d_o,
  output logic [CPU_ID_WIDTH-1:0]                         cpu_id_f2d_o,
  output logic [NUM_REQ-1:0]                              ack_d2f_o,
  output logic [NUM_REQ-1:0][N_CPU-1:0]                   sharers_d2f_o,
  output logic [NUM_REQ-1:0]                              grant_o,
  output logic                                            busy_o,
  output logic                                            timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             r_state, w_next_state;
  logic [NUM_REQ-1:0] r_grant, w_next_grant;
  logic [IDX_W-1:0]   r_last, w_next_last;
  logic [IDX_W-1:0]   r_gidx, w_next_gidx;
  logic [IDX_W-1:0]   w_sel, w_idx;
  logic               w_any;
  logic               w_expire;

  // Scan starts one past the last served requester, so it ranks last next time.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = IDX_W'((int'(r_last) + i) % NUM_REQ);
      if (!w_any && valid_f2d_i[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

`ifdef DIR_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_expire = (r_state == BUSY) && !ack_d2f_i &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (!ack_d2f_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_gidx  <= '0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_last  <= w_next_last;
      r_gidx  <= w_next_gidx;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_grant  = r_grant;
    w_next_last   = r_last;
    w_next_gidx   = r_gidx;
    valid_f2d_o   = 1'b0;
    op_f2d_o      = READ_OP;
    tag_f2d_o     = '0;
    index_f2d_o   = '0;
    cpu_id_f2d_o  = '0;
    ack_d2f_o     = '0;
    sharers_d2f_o = '0;
    timeout_o     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_state = BUSY;
          w_next_grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
          w_next_gidx  = w_sel;
        end
      end
      BUSY: begin
        valid_f2d_o           = valid_f2d_i[r_gidx];
        op_f2d_o              = op_f2d_i[r_gidx];
        tag_f2d_o             = tag_f2d_i[r_gidx];
        index_f2d_o           = index_f2d_i[r_gidx];
        cpu_id_f2d_o          = cpu_id_f2d_i[r_gidx];
        ack_d2f_o[r_gidx]     = ack_d2f_i;
        sharers_d2f_o[r_gidx] = sharers_d2f_i;
        timeout_o             = w_expire;
        // Ack, abandon and forced release all leave through the same IDLE bubble.
        if (ack_d2f_i || !valid_f2d_i[r_gidx] || w_expire) begin
          w_next_state = IDLE;
          w_next_grant = '0;
          w_next_last  = r_gidx;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign grant_o = r_grant;
  assign busy_o  = (r_state == BUSY);

endmodule
